// File: rtl/host_cmd_parser.sv
// Host command frame parser: splits [dest, cmd, len_hi, len_lo, data*len, csum_hi, csum_lo],
// forwards payload with a one-deep output register, checks the 32-bit sum and times out stalled frames.
module host_cmd_parser #(
  parameter int HOST_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [HOST_WIDTH-1:0] in_data,
  input  logic                  in_enable,
  output logic                  in_ready,
  output logic [HOST_WIDTH-1:0] out_data,
  output logic                  out_enable,
  input  logic                  out_ready,
  output logic [7:0]            hdr_dest,
  output logic [7:0]            hdr_cmd,
  output logic [23:0]           hdr_length,
  output logic                  hdr_valid,
  output logic                  frame_done,
  output logic                  checksum_ok,
  output logic                  err_timeout,
  output logic [15:0]           frames_ok,
  output logic [15:0]           frames_bad
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_DEST, S_CMD, S_LENHI, S_LENLO, S_DATA, S_CSUMHI, S_CSUMLO
  } state_t;

  state_t                state, state_nx;
  logic                  rdy_en, accept, to_fire, csum_match;
  logic [23:0]           wcnt, len_nx;
  logic [31:0]           acc;
  logic [HOST_WIDTH-1:0] csum_hi;
  logic [TW-1:0]         tcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_DEST;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (to_fire) begin
      state_nx = S_DEST;
    end else if (accept) begin
      unique case (state)
        S_DEST:   state_nx = S_CMD;
        S_CMD:    state_nx = S_LENHI;
        S_LENHI:  state_nx = S_LENLO;
        S_LENLO:  state_nx = (len_nx == 24'd0) ? S_CSUMHI : S_DATA;
        S_DATA:   state_nx = (wcnt == 24'd1) ? S_CSUMHI : S_DATA;
        S_CSUMHI: state_nx = S_CSUMLO;
        S_CSUMLO: state_nx = S_DEST;
        default:  state_nx = S_DEST;
      endcase
    end
  end

  // rdy_en keeps in_ready low through reset and until the first clock after release
  always_comb begin
    in_ready   = rdy_en & ((state != S_DATA) | !out_enable | out_ready);
    accept     = in_enable & in_ready;
    len_nx     = {hdr_length[23:16], in_data[15:0]};
    csum_match = (32'({csum_hi, in_data}) == acc);
    to_fire    = (TIMEOUT_CYCLES != 0) && (state != S_DEST) && in_ready && !in_enable
                 && (tcnt == TLAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en      <= 1'b0;
      out_data    <= '0;
      out_enable  <= 1'b0;
      hdr_dest    <= '0;
      hdr_cmd     <= '0;
      hdr_length  <= '0;
      hdr_valid   <= 1'b0;
      frame_done  <= 1'b0;
      checksum_ok <= 1'b0;
      err_timeout <= 1'b0;
      frames_ok   <= '0;
      frames_bad  <= '0;
      wcnt        <= '0;
      acc         <= '0;
      csum_hi     <= '0;
      tcnt        <= '0;
    end else begin
      rdy_en      <= 1'b1;
      hdr_valid   <= 1'b0;
      frame_done  <= 1'b0;
      checksum_ok <= 1'b0;
      err_timeout <= 1'b0;

      if (accept && state == S_DATA) begin
        out_data   <= in_data;
        out_enable <= 1'b1;
      end else if (out_ready) begin
        out_enable <= 1'b0;
      end

      // only host-side idling counts; a downstream stall drops in_ready and freezes tcnt
      if (accept || state == S_DEST || to_fire) tcnt <= '0;
      else if (in_ready && !in_enable)          tcnt <= tcnt + 1'b1;

      if (to_fire) begin
        err_timeout <= 1'b1;
        if (frames_bad != 16'hFFFF) frames_bad <= frames_bad + 16'd1;
      end

      if (accept) begin
        unique case (state)
          S_DEST: begin
            hdr_dest <= in_data[7:0];
            acc      <= '0;
          end
          S_CMD:   hdr_cmd <= in_data[7:0];
          S_LENHI: hdr_length[23:16] <= in_data[7:0];
          S_LENLO: begin
            hdr_length[15:0] <= in_data[15:0];
            wcnt             <= len_nx;
            hdr_valid        <= 1'b1;
          end
          S_DATA: begin
            acc  <= acc + 32'(in_data);
            wcnt <= wcnt - 24'd1;
          end
          S_CSUMHI: csum_hi <= in_data;
          S_CSUMLO: begin
            frame_done  <= 1'b1;
            checksum_ok <= csum_match;
            if (csum_match) begin
              if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
            end else begin
              if (frames_bad != 16'hFFFF) frames_bad <= frames_bad + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
